// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Each operation is granted in IDLE, its operands are registered and presented to the
// ALU for one EXEC cycle, and the captured result is held in RESP until the owner
// accepts it.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic             grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_ctrl;

  // The ALU always sees the registered operation; it is only sampled in EXEC.
  assign alu_a    = op_a;
  assign alu_b    = op_b;
  assign alu_ctrl = op_ctrl;

  // Round-robin pick: under contention the requester not served last wins.
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b11:   grant = ~last_grant;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

  // Accept is offered only in IDLE, to the granted requester.
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && req_valid != 2'b00)
      req_ready = grant ? 2'b10 : 2'b01;
  end

  // Control FSM with registered busy/rsp_valid and the operand/result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_ctrl    <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_valid  <= 2'b00;
      busy       <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid != 2'b00) begin
            op_a       <= grant ? req1_a  : req0_a;
            op_b       <= grant ? req1_b  : req0_b;
            op_ctrl    <= grant ? req1_op : req0_op;
            owner      <= grant;
            last_grant <= grant;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= owner ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: begin
          // Only the owner's accept retires the response.
          if (rsp_ready[owner]) begin
            op_count  <= op_count + CNT_W'(1);
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
